// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory stage of the multi-cycle MIPS CPU. Performs one load or store per
// request on a variable-latency, word-wide data bus using a req/ack handshake.
// Byte order is big-endian: byte lane k = addr[1:0] lives in bits
// (31-8k) down to (24-8k).
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   start                  one-cycle request, sampled only while idle
//   we, size, sign_ext     operation: store/load, 00 b / 01 h / 1x w, load extension
//   addr, wdata            effective address and raw store data
//   m_req, m_we, m_addr    memory bus request, write enable, word address
//   m_wdata, m_be          lane-replicated store data and byte enables
//   m_ack, m_rdata         memory acknowledge and read data
//   dy                     registered, extended load result
//   busy, done             activity flag and one-cycle completion pulse
//   addr_err, bus_err      completion status: misaligned / timed out
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic [31:0] dy,
  output logic        busy,
  output logic        done,
  output logic        addr_err,
  output logic        bus_err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR  = 3'd3,
    ST_TOUT = 3'd4
  } state_t;

  // Byte enables for the addressed lane(s); bit 3 covers bits 31:24.
  function automatic logic [3:0] lane_be(input logic [1:0] size_v, input logic [1:0] a_v);
    logic [3:0] be_v;
    case (size_v)
      2'b00:   be_v = 4'b1000 >> a_v;
      2'b01:   be_v = a_v[1] ? 4'b0011 : 4'b1100;
      default: be_v = 4'b1111;
    endcase
    return be_v;
  endfunction

  // Replicate the store byte/halfword across every lane it could occupy.
  function automatic logic [31:0] store_data(input logic [1:0] size_v, input logic [31:0] w_v);
    logic [31:0] d_v;
    case (size_v)
      2'b00:   d_v = {4{w_v[7:0]}};
      2'b01:   d_v = {2{w_v[15:0]}};
      default: d_v = w_v;
    endcase
    return d_v;
  endfunction

  // Pick the addressed byte/halfword out of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [1:0] size_v, input logic sext_v,
                                               input logic [1:0] a_v, input logic [31:0] rd_v);
    logic [7:0]  b_v;
    logic [15:0] h_v;
    logic [31:0] r_v;
    case (a_v)
      2'b00:   b_v = rd_v[31:24];
      2'b01:   b_v = rd_v[23:16];
      2'b10:   b_v = rd_v[15:8];
      default: b_v = rd_v[7:0];
    endcase
    h_v = a_v[1] ? rd_v[15:0] : rd_v[31:16];
    case (size_v)
      2'b00:   r_v = {{24{sext_v & b_v[7]}}, b_v};
      2'b01:   r_v = {{16{sext_v & h_v[15]}}, h_v};
      default: r_v = rd_v;
    endcase
    return r_v;
  endfunction

  // Halfwords need an even address, words (and the reserved size) a 4-aligned one.
  function automatic logic misaligned(input logic [1:0] size_v, input logic [1:0] a_v);
    logic m_v;
    case (size_v)
      2'b00:   m_v = 1'b0;
      2'b01:   m_v = a_v[0];
      default: m_v = (a_v != 2'b00);
    endcase
    return m_v;
  endfunction

  state_t      state_r, next_state_s;
  logic [7:0]  cnt_r, cnt_next_s;
  logic        we_r, sext_r;
  logic [1:0]  size_r, lane_r;
  logic        accept_s, load_dy_s, m_we_next_s;

  // Next-state, timeout counter and control decode.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    load_dy_s    = 1'b0;
    m_we_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (misaligned(size, addr[1:0])) begin
            next_state_s = ST_ERR;
          end else begin
            next_state_s = ST_REQ;
            cnt_next_s   = 8'd0;
            m_we_next_s  = we;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (m_ack) begin
          next_state_s = ST_DONE;
          load_dy_s    = ~we_r;
        end else if ((cnt_r + 8'd1) == TIMEOUT_C) begin
          next_state_s = ST_TOUT;
        end else begin
          cnt_next_s   = cnt_r + 8'd1;
          m_we_next_s  = we_r;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      ST_ERR:  next_state_s = ST_IDLE;
      ST_TOUT: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Capture the request and its bus image when a start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      sext_r  <= 1'b0;
      lane_r  <= 2'b00;
      m_addr  <= 32'd0;
      m_wdata <= 32'd0;
      m_be    <= 4'd0;
    end else if (accept_s) begin
      we_r    <= we;
      size_r  <= size;
      sext_r  <= sign_ext;
      lane_r  <= addr[1:0];
      m_addr  <= {addr[31:2], 2'b00};
      m_wdata <= we ? store_data(size, wdata) : 32'd0;
      m_be    <= lane_be(size, addr[1:0]);
    end
  end

  // Handshake and status outputs, registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      m_req    <= (next_state_s == ST_REQ);
      m_we     <= m_we_next_s;
      busy     <= (next_state_s != ST_IDLE);
      done     <= (next_state_s == ST_DONE) || (next_state_s == ST_ERR) ||
                  (next_state_s == ST_TOUT);
      addr_err <= (next_state_s == ST_ERR);
      bus_err  <= (next_state_s == ST_TOUT);
    end
  end

  // Load result register; only a successful load changes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dy <= 32'd0;
    end else if (load_dy_s) begin
      dy <= load_extract(size_r, sext_r, lane_r, m_rdata);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Each transaction is described by its
// operation and the cycle its ack arrives; a timeline model derives what every
// output must be in each cycle and one compare process checks it at negedge.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        m_req, m_we, m_ack = 1'b0;
  logic [31:0] m_addr, m_wdata, m_rdata = 32'd0, dy;
  logic [3:0]  m_be;
  logic        busy, done, addr_err, bus_err;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata), .dy(dy), .busy(busy), .done(done),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // current transaction descriptor and model state
  logic        d_we, d_sext;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  int          d_ack_at;
  int          cur_k;
  bit          txn_active = 1'b0;
  bit          chk_en = 1'b0;
  logic [31:0] dy_model = 32'd0;

  // snapshots taken in the first cycle after start
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;
  logic        snap_we, snap_req, snap_done, snap_aerr;
  int          req_cycles;

  function automatic bit exp_mis(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return 1'b0;
    else if (sz == 2'd1) return a[0];
    else return (a != 2'd0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sx,
                                           input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * (3 - int'(a)))) & 32'h0000_00FF;
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * (1 - int'(a[1])))) & 32'h0000_FFFF;
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return 4'(1 << (3 - int'(a)));
    else if (sz == 2'd1) return a[1] ? 4'h3 : 4'hC;
    else return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic w, input logic [1:0] sz, input logic [31:0] d);
    if (!w) return 32'd0;
    else if (sz == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
    else if (sz == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
    else return d;
  endfunction

  function automatic int active_len(input bit mis, input int ack_at);
    if (mis) return 0;
    else if (ack_at != 0) return ack_at;
    else return TMO;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the timeline model.
  always @(negedge clk) begin : compare
    bit          mis, req_e, done_e, busy_e, ok_load;
    int          len;
    logic [31:0] dy_e;
    if (chk_en) begin
      if (!txn_active) begin
        chk("idle_m_req", 32'(m_req), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_dy", dy, dy_model);
      end else begin
        mis     = exp_mis(d_size, d_addr[1:0]);
        len     = active_len(mis, d_ack_at);
        req_e   = !mis && cur_k >= 1 && cur_k <= len;
        done_e  = (cur_k == len + 1);
        busy_e  = cur_k >= 1 && cur_k <= len + 1;
        ok_load = !mis && d_ack_at != 0 && !d_we;
        dy_e    = (ok_load && cur_k >= len + 1) ? exp_load(d_size, d_sext, d_addr[1:0], d_rdata)
                                                : dy_model;
        chk("m_req", 32'(m_req), 32'(req_e));
        chk("busy", 32'(busy), 32'(busy_e));
        chk("done", 32'(done), 32'(done_e));
        chk("addr_err", 32'(addr_err), 32'(done_e && mis));
        chk("bus_err", 32'(bus_err), 32'(done_e && !mis && d_ack_at == 0));
        chk("dy", dy, dy_e);
        if (req_e) begin
          chk("m_addr", m_addr, d_addr & 32'hFFFF_FFFC);
          chk("m_be", 32'(m_be), 32'(exp_be(d_size, d_addr[1:0])));
          chk("m_wdata", m_wdata, exp_wdata(d_we, d_size, d_wdata));
          chk("m_we", 32'(m_we), 32'(d_we));
        end
      end
    end
  end

  // Issue one request; ack_at = 0 means never acknowledge. poke fires a
  // conflicting start while the request is in flight.
  task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int ack_at, input bit poke);
    int len;
    @(posedge clk); #1;
    d_we = w; d_size = sz; d_sext = sx; d_addr = a; d_wdata = wd; d_rdata = rd;
    d_ack_at = ack_at; cur_k = 0; txn_active = 1'b1; req_cycles = 0;
    start = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    len = active_len(exp_mis(sz, a[1:0]), ack_at);
    for (int k = 1; k <= len + 2; k++) begin
      @(posedge clk); #1;
      cur_k = k;
      start = poke && (k == 2);
      if (poke && k == 2) begin
        we = 1'b1; size = 2'd2; addr = 32'h0000_0F00; wdata = 32'hFFFF_FFFF;
      end
      m_ack   = (k == ack_at);
      m_rdata = (k == ack_at) ? rd : 32'h0BAD_F00D;
      if (m_req) req_cycles++;
      if (k == 1) begin
        snap_addr = m_addr; snap_wdata = m_wdata; snap_be = m_be; snap_we = m_we;
        snap_req = m_req; snap_done = done; snap_aerr = addr_err;
      end
    end
    if (!exp_mis(sz, a[1:0]) && ack_at != 0 && !w) dy_model = exp_load(sz, sx, a[1:0], rd);
    txn_active = 1'b0;
    m_ack = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_errs", 32'({addr_err, bus_err, m_we}), 32'd0);
    chk("rst_dy", dy, 32'd0);
    chk("rst_bus", m_addr | m_wdata | 32'(m_be), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    chk_en = 1'b1;

    // aligned lw, ack two cycles after m_req rises
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'd0, 32'hDEAD_BEEF, 3, 1'b0);
    chk("lw_m_addr", snap_addr, 32'h0000_0104);
    chk("lw_m_be", 32'(snap_be), 32'h0000_000F);
    chk("lw_dy", dy, 32'hDEAD_BEEF);
    chk("lw_req_cycles", 32'(req_cycles), 32'd3);

    // byte and halfword loads from 0x80FF_7F01
    do_op(1'b0, 2'd0, 1'b1, 32'h0000_0200, 32'd0, 32'h80FF_7F01, 1, 1'b0);
    chk("lb0_dy", dy, 32'hFFFF_FF80);
    do_op(1'b0, 2'd0, 1'b0, 32'h0000_0200, 32'd0, 32'h80FF_7F01, 2, 1'b0);
    chk("lbu0_dy", dy, 32'h0000_0080);
    do_op(1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'd0, 32'h80FF_7F01, 1, 1'b0);
    chk("lb3_dy", dy, 32'h0000_0001);
    do_op(1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'd0, 32'h80FF_7F01, 3, 1'b0);
    chk("lh2_dy", dy, 32'h0000_7F01);
    do_op(1'b0, 2'd1, 1'b0, 32'h0000_0200, 32'd0, 32'h80FF_7F01, 1, 1'b0);
    chk("lhu0_dy", dy, 32'h0000_80FF);

    // stores leave dy alone
    do_op(1'b1, 2'd0, 1'b0, 32'h0000_0302, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1'b0);
    chk("sb_m_wdata", snap_wdata, 32'h7878_7878);
    chk("sb_m_be", 32'(snap_be), 32'h0000_0002);
    chk("sb_m_we", 32'(snap_we), 32'd1);
    chk("sb_dy", dy, 32'h0000_80FF);
    do_op(1'b1, 2'd1, 1'b0, 32'h0000_0300, 32'h1234_5678, 32'hFFFF_FFFF, 2, 1'b0);
    chk("sh_m_wdata", snap_wdata, 32'h5678_5678);
    chk("sh_m_be", 32'(snap_be), 32'h0000_000C);
    chk("sh_dy", dy, 32'h0000_80FF);

    // misaligned requests never reach the bus
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'd0, 32'd0, 0, 1'b0);
    chk("mis_lw_req", 32'(snap_req), 32'd0);
    chk("mis_lw_done", 32'({snap_done, snap_aerr}), 32'd3);
    chk("mis_lw_dy", dy, 32'h0000_80FF);
    do_op(1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'hAAAA_5555, 32'd0, 0, 1'b0);
    chk("mis_sh_req", 32'(req_cycles), 32'd0);
    chk("mis_sh_done", 32'({snap_done, snap_aerr}), 32'd3);

    // timeout, with a start issued during REQ that must be ignored
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'd0, 32'd0, 0, 1'b1);
    chk("tout_req_cycles", 32'(req_cycles), 32'd4);
    chk("tout_dy", dy, 32'h0000_80FF);

    // asynchronous reset in the middle of a request
    chk_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h0000_0500;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_rst_m_req", 32'(m_req), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrst_m_req", 32'(m_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dy", dy, 32'd0);
    dy_model = 32'd0;
    @(posedge clk); #2;
    reset = 1'b0;
    chk_en = 1'b1;

    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0504, 32'd0, 32'hCAFE_F00D, 2, 1'b0);
    chk("post_rst_dy", dy, 32'hCAFE_F00D);

    // stale ack while idle
    @(posedge clk); #1;
    m_ack = 1'b1; m_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    m_ack = 1'b0;
    chk("stale_done", 32'(done), 32'd0);
    chk("stale_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("stale_dy", dy, 32'hCAFE_F00D);
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the multi-cycle MIPS CPU. It takes the registered ALU result as the effective address and the registered RT value as store data.
- Runs one load or store per request on a variable-latency word-wide data-memory bus using a req/ack handshake.
- Returns the aligned, extended load word on DY, which the integer datapath registers and selects on Y_Sel = 3.
- Reports misaligned addresses and bus timeouts to the control unit.

Parameters:
- TIMEOUT, 16: maximum cycles m_req may stay high without m_ack before the access is aborted. Legal range 1 to 255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  one-cycle request from the control unit. Sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  32  effective address (ALU_OUT).
- wdata  input  32  store data (D_OUT). Byte in bits 7:0, halfword in bits 15:0.
- m_req  output  1  memory request.
- m_we  output  1  memory write enable.
- m_addr  output  32  word address: {addr[31:2], 2'b00}.
- m_wdata  output  32  lane-replicated store data.
- m_be  output  4  byte enables. Bit 3 = bits 31:24.
- m_ack  input  1  memory acknowledge, sampled each cycle while m_req is high.
- m_rdata  input  32  read data, valid in the cycle m_ack is high.
- dy  output  32  load result, feeds DY.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- addr_err  output  1  valid with done: misaligned access.
- bus_err  output  1  valid with done: timeout.

Behaviour:
- Byte order is big-endian. Byte lane k = addr[1:0] maps to bits (31-8k) down to (24-8k).
- On accepted start, latch we, size, sign_ext, addr[1:0], m_addr, m_wdata and m_be.
- Store lane replication:
  - sb: m_wdata = {4{wdata[7:0]}}, m_be = 4'b1000 >> addr[1:0].
  - sh: m_wdata = {2{wdata[15:0]}}, m_be = 1100 when addr[1] = 0, 0011 when addr[1] = 1.
  - sw: m_wdata = wdata, m_be = 1111.
- For loads, m_be follows the same lane rule and m_wdata = 0.
- Alignment rules: a halfword with addr[0] = 1 is misaligned; a word with addr[1:0] != 0 is misaligned.
- State machine:
  - IDLE: start with aligned address goes to REQ. Start with misaligned address goes to ERR. No start: stay.
  - REQ: m_req = 1 and m_we = latched we. Clear timeout counter on entry and increment each REQ cycle.
    - m_ack = 1: capture and extract the load result into the dy register when a load; go to DONE.
    - Counter reaches TIMEOUT with no ack: go to TOUT.
  - DONE: done = 1 for one cycle; go to IDLE.
  - ERR: done = 1, addr_err = 1 for one cycle; no bus activity; go to IDLE.
  - TOUT: done = 1, bus_err = 1 for one cycle; m_req already low; go to IDLE.
- Latency: start at cycle 0 puts m_req high at cycle 1. If m_ack arrives at cycle n, done is high at cycle n+1. The minimum is an ack at cycle 1, giving done at cycle 2.
- m_req drops in the cycle after m_ack is sampled. Address, write data and byte enables stay stable while m_req is high.
- Load extraction: select the byte or halfword by latched addr[1:0], then sign- or zero-extend to 32 bits. A word load passes through unchanged.
- dy is registered. It updates only on a successful load and holds its value across stores, errors and timeouts.
- start while busy is ignored; there is no queuing.
- An m_ack outside REQ is ignored.
- Reset values: all outputs 0, state IDLE, counter 0, dy 0.
- Reset asserted mid-transaction forces m_req low immediately (asynchronous) and discards the access.
- A store has no dy side effect. A timed-out store may or may not have been written; software treats it as lost.

Test Plan:
- Aligned lw: addr 0x0000_0104 with m_ack returned 2 cycles after m_req rises and m_rdata 0xDEAD_BEEF → m_addr 0x104, m_be 1111, done exactly 1 cycle after ack, dy 0xDEAD_BEEF, busy low the following cycle.
- Sign/zero byte and halfword loads with m_rdata 0x80FF_7F01:
  - lb at addr[1:0] = 0 → dy 0xFFFF_FF80.
  - lbu at addr[1:0] = 0 → dy 0x0000_0080.
  - lb at addr[1:0] = 3 → dy 0x0000_0001.
  - lh at addr[1:0] = 2 → dy 0x0000_7F01.
  - lhu at addr[1:0] = 0 → dy 0x0000_80FF.
- Stores with wdata 0x1234_5678:
  - sb at addr[1:0] = 2 → m_wdata 0x7878_7878, m_be 0010, m_we 1.
  - sh at addr[1:0] = 0 → m_wdata 0x5678_5678, m_be 1100.
  - In both cases dy is unchanged.
- Misaligned: lw at 0x102 and sh at 0x101 → m_req never rises; done and addr_err high at cycle 1; dy unchanged.
- Timeout with TIMEOUT = 4: m_ack never asserted → m_req high for exactly 4 cycles, then done and bus_err pulse; a start issued during REQ is ignored.
- Reset mid-REQ: assert reset between clock edges → m_req, busy and dy go to 0 immediately. After release, a fresh lw completes normally, and a stale m_ack arriving in IDLE produces no done.
